ext_mem_bridge: RTL and testbench

//  Bus-cycle sequencer between the 6502 datapath core and an external async SRAM.
//  It replaces the free-running clock divider: the core advances only on a cpu_ce pulse.
//  One pulse is issued per completed memory access, with programmable strobe width.

---
 rtl/ext_mem_bridge.sv | 162 ++++++++++++++++
 tb/tb_ext_mem_bridge.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_bridge.sv
// ext_mem_bridge: bus-cycle sequencer between the 6502 datapath core and an
// external asynchronous SRAM. Each access runs IDLE -> SETUP -> STROBE x N ->
// HOLD, and the core gets exactly one cpu_ce pulse per completed access.
// Accesses start back-to-back while run_en is high, or one at a time from
// rising edges of the step button.
module ext_mem_bridge #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rw,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ce,
  input  logic        run_en,
  input  logic        step,
  output logic [7:0]  mem_addr_l,
  output logic [7:0]  mem_addr_h,
  output logic [7:0]  mem_data_out,
  output logic        mem_data_oe,
  input  logic [7:0]  mem_data_in,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        busy,
  output logic [15:0] bus_cycles
);

  // A strobe width of zero would give no strobe at all, so it is clamped to one.
  localparam int EFF_WAIT = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CW       = (EFF_WAIT > 1) ? $clog2(EFF_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(EFF_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          rw_q, rw_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          ce_q, ce_d;
  logic          data_oe_q, data_oe_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          busy_q, busy_d;
  logic [15:0]   bus_cycles_q, bus_cycles_d;
  logic          step_q;
  logic          pending_q, pending_d;
  logic          step_edge;

  assign step_edge = step & ~step_q;

  // Next-state, latched access fields, and the next value of every output flop.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rw_d         = rw_q;
    rdata_d      = rdata_q;
    bus_cycles_d = bus_cycles_q;
    pending_d    = pending_q | step_edge;

    case (state_q)
      S_IDLE: begin
        if (run_en || pending_q) begin
          addr_d    = cpu_addr;
          wdata_d   = cpu_wdata;
          rw_d      = cpu_rw;
          // Starting an access consumes any pending step, including an edge
          // arriving in this same cycle.
          pending_d = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d      = S_HOLD;
          bus_cycles_d = bus_cycles_q + 16'd1;
          if (rw_q) begin
            rdata_d = mem_data_in;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the flops line up with state_q.
    ce_d      = (state_d == S_HOLD);
    oe_n_d    = !((state_d == S_STROBE) && rw_d);
    we_n_d    = !((state_d == S_STROBE) && !rw_d);
    data_oe_d = (state_d != S_IDLE) && !rw_d;
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset; reset aborts any access.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rw_q         <= 1'b1;
      rdata_q      <= '0;
      ce_q         <= 1'b0;
      data_oe_q    <= 1'b0;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      bus_cycles_q <= '0;
      step_q       <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rw_q         <= rw_d;
      rdata_q      <= rdata_d;
      ce_q         <= ce_d;
      data_oe_q    <= data_oe_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      busy_q       <= busy_d;
      bus_cycles_q <= bus_cycles_d;
      step_q       <= step;
      pending_q    <= pending_d;
    end
  end

  assign cpu_rdata    = rdata_q;
  assign cpu_ce       = ce_q;
  assign mem_addr_l   = addr_q[7:0];
  assign mem_addr_h   = addr_q[15:8];
  assign mem_data_out = wdata_q;
  assign mem_data_oe  = data_oe_q;
  assign mem_oe_n     = oe_n_q;
  assign mem_we_n     = we_n_q;
  assign busy         = busy_q;
  assign bus_cycles   = bus_cycles_q;

endmodule

// File: tb/tb_ext_mem_bridge.sv
// tb_ext_mem_bridge: directed bench for ext_mem_bridge with WAIT_CYCLES=2,
// an asynchronous SRAM model and negedge activity monitors.
module tb_ext_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_rw = 1'b1;
  logic [7:0]  cpu_rdata;
  logic        cpu_ce;
  logic        run_en = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  mem_addr_l;
  logic [7:0]  mem_addr_h;
  logic [7:0]  mem_data_out;
  logic        mem_data_oe;
  logic [7:0]  mem_data_in;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic        busy;
  logic [15:0] bus_cycles;

  int n_assert = 0;
  int n_fail   = 0;

  // Activity counters, only ever incremented; the stimulus takes deltas.
  int ce_cnt   = 0;
  int oe_low   = 0;
  int we_low   = 0;
  int both_low = 0;

  logic [7:0] sram [0:65535];

  ext_mem_bridge #(.WAIT_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rw       (cpu_rw),
    .cpu_rdata    (cpu_rdata),
    .cpu_ce       (cpu_ce),
    .run_en       (run_en),
    .step         (step),
    .mem_addr_l   (mem_addr_l),
    .mem_addr_h   (mem_addr_h),
    .mem_data_out (mem_data_out),
    .mem_data_oe  (mem_data_oe),
    .mem_data_in  (mem_data_in),
    .mem_oe_n     (mem_oe_n),
    .mem_we_n     (mem_we_n),
    .busy         (busy),
    .bus_cycles   (bus_cycles)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: combinational read, write while we_n is low.
  assign mem_data_in = sram[{mem_addr_h, mem_addr_l}];

  always @(negedge clk) begin
    if (!rst_n) sram[16'hFFFC] <= 8'hA9;
    else if (!mem_we_n && mem_data_oe) sram[{mem_addr_h, mem_addr_l}] <= mem_data_out;
  end

  always @(negedge clk) begin
    if (cpu_ce === 1'b1) ce_cnt++;
    if (mem_oe_n === 1'b0) oe_low++;
    if (mem_we_n === 1'b0) we_low++;
    if (mem_oe_n === 1'b0 && mem_we_n === 1'b0) both_low++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int ce0, oe0, we0;
  int first_ce, second_ce;
  logic [15:0] b1, b2;
  logic [7:0] sram_val;

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ce", cpu_ce, 0);
    chk("rst_oe_n", mem_oe_n, 1);
    chk("rst_we_n", mem_we_n, 1);
    chk("rst_data_oe", mem_data_oe, 0);
    chk("rst_bus_cycles", bus_cycles, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_addr", {mem_addr_h, mem_addr_l}, 0);
    chk("rst_data_out", mem_data_out, 0);
    rst_n = 1'b1;

    // Idle for 20 clocks
    ce0 = ce_cnt;
    repeat (20) tick();
    chk("idle_busy", busy, 0);
    chk("idle_ce", cpu_ce, 0);
    chk("idle_oe_n", mem_oe_n, 1);
    chk("idle_we_n", mem_we_n, 1);
    chk("idle_bus_cycles", bus_cycles, 0);
    chk("idle_ce_count", ce_cnt - ce0, 0);

    // Reset during the second STROBE cycle of a write aborts it
    ce0 = ce_cnt;
    cpu_addr = 16'h0300; cpu_wdata = 8'h77; cpu_rw = 1'b0; run_en = 1'b1;
    tick();
    run_en = 1'b0;
    chk("abort_setup_busy", busy, 1);
    tick();
    chk("abort_strobe1_we_n", mem_we_n, 0);
    tick();
    chk("abort_strobe2_we_n", mem_we_n, 0);
    rst_n = 1'b0;
    tick();
    chk("abort_we_n", mem_we_n, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ce", cpu_ce, 0);
    chk("abort_data_oe", mem_data_oe, 0);
    chk("abort_bus_cycles", bus_cycles, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("abort_no_ce", ce_cnt - ce0, 0);
    chk("abort_stay_idle", busy, 0);

    // Read FFFC with a one-cycle run_en pulse
    ce0 = ce_cnt; oe0 = oe_low;
    cpu_addr = 16'hFFFC; cpu_rw = 1'b1; run_en = 1'b1;
    tick();
    run_en = 1'b0;
    chk("rd_setup_busy", busy, 1);
    chk("rd_setup_oe_n", mem_oe_n, 1);
    chk("rd_setup_addr", {mem_addr_h, mem_addr_l}, 16'hFFFC);
    chk("rd_setup_data_oe", mem_data_oe, 0);
    tick();
    chk("rd_strobe1_oe_n", mem_oe_n, 0);
    tick();
    chk("rd_strobe2_oe_n", mem_oe_n, 0);
    chk("rd_strobe2_ce", cpu_ce, 0);
    tick();
    chk("rd_hold_ce", cpu_ce, 1);
    chk("rd_hold_oe_n", mem_oe_n, 1);
    chk("rd_rdata", cpu_rdata, 8'hA9);
    chk("rd_bus_cycles", bus_cycles, 1);
    tick();
    chk("rd_idle_ce", cpu_ce, 0);
    chk("rd_idle_busy", busy, 0);
    repeat (3) tick();
    chk("rd_ce_count", ce_cnt - ce0, 1);
    chk("rd_oe_low_count", oe_low - oe0, 2);
    chk("rd_rdata_held", cpu_rdata, 8'hA9);

    // Write 5A to 0200
    ce0 = ce_cnt; oe0 = oe_low; we0 = we_low;
    cpu_addr = 16'h0200; cpu_wdata = 8'h5A; cpu_rw = 1'b0; run_en = 1'b1;
    tick();
    run_en = 1'b0;
    cpu_addr = 16'h1234; cpu_wdata = 8'hEE; cpu_rw = 1'b1;
    chk("wr_setup_data_oe", mem_data_oe, 1);
    chk("wr_setup_we_n", mem_we_n, 1);
    chk("wr_setup_data", mem_data_out, 8'h5A);
    tick();
    chk("wr_strobe1_we_n", mem_we_n, 0);
    chk("wr_strobe1_addr", {mem_addr_h, mem_addr_l}, 16'h0200);
    tick();
    chk("wr_strobe2_we_n", mem_we_n, 0);
    chk("wr_strobe2_data_oe", mem_data_oe, 1);
    tick();
    chk("wr_hold_we_n", mem_we_n, 1);
    chk("wr_hold_data_oe", mem_data_oe, 1);
    chk("wr_hold_ce", cpu_ce, 1);
    chk("wr_bus_cycles", bus_cycles, 2);
    tick();
    chk("wr_idle_data_oe", mem_data_oe, 0);
    chk("wr_idle_addr_held", {mem_addr_h, mem_addr_l}, 16'h0200);
    repeat (3) tick();
    sram_val = sram[16'h0200];
    chk("wr_sram", sram_val, 8'h5A);
    chk("wr_we_low_count", we_low - we0, 2);
    chk("wr_oe_low_count", oe_low - oe0, 0);
    chk("wr_ce_count", ce_cnt - ce0, 1);

    // Single-step: edge while idle, edge while busy (pending), edge while pending (dropped)
    ce0 = ce_cnt;
    cpu_addr = 16'h0200; cpu_rw = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    chk("step1_busy", busy, 1);
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_between_busy", busy, 0);
    tick();
    chk("step2_busy", busy, 1);
    repeat (9) tick();
    chk("step_ce_count", ce_cnt - ce0, 2);
    chk("step_bus_cycles", bus_cycles, 4);
    chk("step_rdata", cpu_rdata, 8'h5A);
    chk("step_end_busy", busy, 0);

    // Counter wrap with back-to-back accesses
    force dut.bus_cycles_q = 16'hFFFE;
    tick();
    release dut.bus_cycles_q;
    tick();
    chk("wrap_preload", bus_cycles, 16'hFFFE);
    ce0 = ce_cnt;
    first_ce = 0; second_ce = 0; b1 = '0; b2 = '0;
    cpu_addr = 16'hFFFC; cpu_rw = 1'b1; run_en = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (cpu_ce === 1'b1) begin
        if (first_ce == 0) begin
          first_ce = c; b1 = bus_cycles;
        end else begin
          second_ce = c; b2 = bus_cycles;
        end
      end
    end
    run_en = 1'b0;
    chk("wrap_first_ce_cycle", first_ce, 4);
    chk("wrap_first_count", b1, 16'hFFFF);
    chk("wrap_ce_period", second_ce - first_ce, 5);
    chk("wrap_second_count", b2, 16'h0000);
    repeat (4) tick();
    chk("wrap_end_busy", busy, 0);
    chk("wrap_ce_count", ce_cnt - ce0, 2);
    chk("wrap_final_count", bus_cycles, 16'h0000);

    chk("strobes_never_both_low", both_low, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
